// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: drains the read port of an async FIFO into a credit-checked skid buffer
// and presents the words in FIFO order on a valid/ready stream.
module fifo_rd_drain #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic             r_clk,
    input  logic             r_rst,
    input  logic             drain_en,
    input  logic             empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             r_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int OW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]    head, tail;
    logic [OW-1:0]    occ;
    logic             inflight, pop, credit;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop       = out_valid & out_ready;
    assign out_valid = occ != '0;
    assign out_data  = out_valid ? mem[head] : '0;
    assign busy      = (state != IDLE) | out_valid | inflight;
    // A slot freed by this cycle's pop can be claimed by a read issued in the same cycle.
    assign credit    = (OW+1)'(occ) + (OW+1)'(inflight) < (OW+1)'(BUF_DEPTH) + (OW+1)'(pop);

    always_comb begin
        state_next = state;
        r_en       = 1'b0;
        case (state)
            IDLE: state_next = drain_en ? RUN : IDLE;
            RUN: begin
                state_next = drain_en ? RUN : STOP;
                r_en       = !r_rst && !empty && credit;
            end
            STOP: state_next = drain_en ? RUN : (!inflight && !out_valid) ? IDLE : STOP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state    <= IDLE;
            inflight <= 1'b0;
            occ      <= '0;
            head     <= '0;
            tail     <= '0;
            rd_count <= '0;
        end else begin
            state    <= state_next;
            inflight <= r_en;
            occ      <= occ + OW'(inflight) - OW'(pop);
            tail     <= inflight ? nxt(tail) : tail;
            head     <= pop ? nxt(head) : head;
            rd_count <= rd_count + CNT_W'(pop);
        end
    end

    always_ff @(posedge r_clk) begin
        if (!r_rst && inflight)
            mem[tail] <= fifo_dout;
    end
endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: directed and random drain scenarios checked against a queue-based model
// of the read stream; a second instance with a 4-bit counter covers the count wrap.
module tb_fifo_rd_drain;
    localparam int BD = 2;

    logic        clk = 1'b0;
    logic        rst, drain_en, empty, out_ready;
    logic [7:0]  fifo_dout;
    logic        r_en, out_valid, busy, r_en4, out_valid4, busy4;
    logic [7:0]  out_data, out_data4;
    logic [15:0] rd_count;
    logic [3:0]  rd_count4;

    always #5 clk = ~clk;

    fifo_rd_drain u0 (
        .r_clk(clk), .r_rst(rst), .drain_en(drain_en), .empty(empty), .fifo_dout(fifo_dout),
        .r_en(r_en), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .rd_count(rd_count)
    );

    fifo_rd_drain #(.CNT_W(4)) u4 (
        .r_clk(clk), .r_rst(rst), .drain_en(drain_en), .empty(empty), .fifo_dout(fifo_dout),
        .r_en(r_en4), .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
        .busy(busy4), .rd_count(rd_count4)
    );

    int         checks = 0, failures = 0;
    logic [7:0] fifo_q[$], buf_q[$];
    logic [7:0] infl_word;
    logic       infl_m, run_m, active_m, hold_empty;
    int         cnt_m, ren_pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic upd_empty();
        empty = hold_empty || fifo_q.size() == 0;
    endtask

    task automatic push(input logic [7:0] w);
        fifo_q.push_back(w);
        upd_empty();
    endtask

    task automatic step();
        int         occ_e;
        logic       pop_e, ren_e, ren_a;
        logic [7:0] head_e;
        @(negedge clk);
        occ_e  = buf_q.size();
        head_e = occ_e != 0 ? buf_q[0] : 8'h00;
        pop_e  = occ_e != 0 && out_ready;
        ren_e  = !rst && run_m && !empty && (occ_e + int'(infl_m) - int'(pop_e) < BD);
        ren_a  = r_en;
        chk("out_valid", 32'(out_valid), 32'(occ_e != 0));
        chk("out_data", 32'(out_data), 32'(head_e));
        chk("r_en", 32'(r_en), 32'(ren_e));
        chk("busy", 32'(busy), 32'(active_m || occ_e != 0 || infl_m));
        chk("rd_count", 32'(rd_count), 32'(cnt_m[15:0]));
        chk("rd_count4", 32'(rd_count4), 32'(cnt_m[3:0]));
        chk("r_en4", 32'(r_en4), 32'(ren_e));
        @(posedge clk);
        #1;
        if (rst) begin
            buf_q.delete();
            infl_m   = 1'b0;
            cnt_m    = 0;
            active_m = 1'b0;
            run_m    = 1'b0;
        end else begin
            if (pop_e) begin
                void'(buf_q.pop_front());
                cnt_m++;
            end
            if (infl_m) buf_q.push_back(infl_word);
            active_m = drain_en || run_m || (active_m && (infl_m || occ_e != 0));
            run_m    = drain_en;
            infl_m   = ren_a;
        end
        if (ren_a && fifo_q.size() != 0) begin
            infl_word = fifo_q.pop_front();
            fifo_dout = infl_word;
            ren_pulses++;
        end
        upd_empty();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; drain_en = 1'b0; out_ready = 1'b0; hold_empty = 1'b0; fifo_dout = 8'h00;
        infl_m = 1'b0; run_m = 1'b0; active_m = 1'b0; cnt_m = 0; ren_pulses = 0; infl_word = 8'h00;
        upd_empty();
        @(posedge clk);
        #1;
        reset_pulse();
        step();

        // Back-to-back drain of eight words with the sink always ready
        for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
        drain_en = 1'b1; out_ready = 1'b1; ren_pulses = 0;
        repeat (12) step();
        chk("t1_reads", 32'(ren_pulses), 32'd8);
        chk("t1_count", 32'(rd_count), 32'd8);

        // Stalled sink: only the skid buffer fills, head word held
        out_ready = 1'b0; ren_pulses = 0;
        for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
        repeat (10) step();
        chk("t2_reads", 32'(ren_pulses), 32'd2);
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_head", 32'(out_data), 32'h21);
        out_ready = 1'b1;
        repeat (8) step();

        // Stop draining while a read is in flight
        for (int i = 0; i < 6; i++) push(8'h31 + 8'(i));
        step();
        drain_en = 1'b0;
        step();
        repeat (6) step();
        chk("t3_busy", 32'(busy), 32'd0);
        fifo_q.delete(); upd_empty();

        // Reset while words are held and in flight
        for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
        drain_en = 1'b1; out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        step();
        reset_pulse();
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_count", 32'(rd_count), 32'd0);
        step();
        step();
        fifo_q.delete(); upd_empty();
        repeat (4) step();

        // FIFO goes empty mid-burst, then refills
        for (int i = 0; i < 8; i++) push(8'h51 + 8'(i));
        ren_pulses = 0;
        for (int k = 0; k < 20 && ren_pulses < 3; k++) step();
        hold_empty = 1'b1; upd_empty();
        repeat (4) step();
        chk("t5_reads", 32'(ren_pulses), 32'd3);
        hold_empty = 1'b0; upd_empty();
        repeat (10) step();

        // Counter wrap on the 4-bit instance
        reset_pulse();
        for (int i = 0; i < 17; i++) push(8'h60 + 8'(i));
        drain_en = 1'b1; out_ready = 1'b1;
        repeat (22) step();
        chk("t6_count4", 32'(rd_count4), 32'd1);
        chk("t6_count", 32'(rd_count), 32'd17);

        // drain_en toggled every cycle
        for (int i = 0; i < 10; i++) push(8'(i * 7 + 3));
        for (int i = 0; i < 30; i++) begin
            drain_en = ~drain_en;
            out_ready = 1'($urandom_range(1));
            step();
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) != 0) push(8'($urandom));
            if ($urandom_range(9) == 0) drain_en = ~drain_en;
            out_ready  = $urandom_range(3) != 0;
            hold_empty = $urandom_range(7) == 0;
            upd_empty();
            step();
        end
        drain_en = 1'b1; out_ready = 1'b1; hold_empty = 1'b0; upd_empty();
        for (int k = 0; k < 500 && fifo_q.size() != 0; k++) step();
        repeat (6) step();
        chk("final_fifo_drained", 32'(fifo_q.size()), 32'd0);
        chk("final_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
